// File: rtl/hex_ascii_pkg.sv
// ============================================================================
// hex_ascii_pkg : shared constants for the ASCII-hex decoder    rev 1.0
// ============================================================================
`default_nettype none

package hex_ascii_pkg;

   localparam logic [0:0] c_ST_EXPECT_HI = 1'b0;
   localparam logic [0:0] c_ST_EXPECT_LO = 1'b1;

   localparam logic [1:0] c_ERR_TIMEOUT = 2'd0;
   localparam logic [1:0] c_ERR_ODD     = 2'd1;
   localparam logic [1:0] c_ERR_BADCHR  = 2'd2;
   localparam logic [1:0] c_ERR_OVERRUN = 2'd3;

   localparam logic [7:0] c_ASCII_CR    = 8'h0D;
   localparam logic [7:0] c_ASCII_LF    = 8'h0A;
   localparam logic [7:0] c_ASCII_SPACE = 8'h20;

endpackage

`default_nettype wire

// File: rtl/ascii_to_nibble.sv
// ============================================================================
// ascii_to_nibble : classifies one ASCII character as hex digit / separator
// rev 1.0
// ============================================================================
`default_nettype none

module ascii_to_nibble
   import hex_ascii_pkg::*;
#(
   parameter bit LOWERCASE_EN = 1'b1
) (
   input  logic [7:0] char_i,
   output logic [3:0] nibble_o,
   output logic       is_digit_o,
   output logic       is_sep_o,
   output logic       is_eol_o
);

   always_comb begin
      nibble_o   = 4'd0;
      is_digit_o = 1'b0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         is_digit_o = 1'b1;
         nibble_o   = char_i[3:0];
      end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
         // 'A'..'F' low bits are 1..6, so adding 9 gives 10..15
         is_digit_o = 1'b1;
         nibble_o   = char_i[3:0] + 4'd9;
      end else if (LOWERCASE_EN && char_i >= 8'h61 && char_i <= 8'h66) begin
         is_digit_o = 1'b1;
         nibble_o   = char_i[3:0] + 4'd9;
      end
   end

   assign is_eol_o = (char_i == c_ASCII_CR) || (char_i == c_ASCII_LF);
   assign is_sep_o = is_eol_o || (char_i == c_ASCII_SPACE);

endmodule

`default_nettype wire

// File: rtl/hex_ascii_decoder.sv
// ============================================================================
// hex_ascii_decoder : pairs ASCII hex digits into bytes with valid/ready out,
// error strobes, inter-nibble timeout and end-of-line byte counts. rev 1.0
// ============================================================================
`default_nettype none

module hex_ascii_decoder
   import hex_ascii_pkg::*;
#(
   parameter bit          LOWERCASE_EN   = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   input  logic [7:0] in_data_i,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   input  logic       out_ready_i,
   output logic       err_valid_o,
   output logic [1:0] err_code_o,
   output logic       eol_o,
   output logic [7:0] line_bytes_o
);

   localparam int          CW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned c_TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] c_TO_LAST = CW'(c_TO_LAST_I);

   logic [3:0]    w_nib;
   logic          w_is_digit, w_is_sep, w_is_eol;

   logic [0:0]    state_q, state_d;
   logic [3:0]    hi_q, hi_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          err_valid_q, err_valid_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          eol_q, eol_d;
   logic [7:0]    line_bytes_q, line_bytes_d;
   logic [7:0]    line_cnt_q, line_cnt_d;
   logic [CW-1:0] to_cnt_q, to_cnt_d;

   ascii_to_nibble #(
      .LOWERCASE_EN (LOWERCASE_EN)
   ) u_classify (
      .char_i     (in_data_i),
      .nibble_o   (w_nib),
      .is_digit_o (w_is_digit),
      .is_sep_o   (w_is_sep),
      .is_eol_o   (w_is_eol)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      err_valid_d  = 1'b0;
      err_code_d   = err_code_q;
      eol_d        = 1'b0;
      line_bytes_d = line_bytes_q;
      line_cnt_d   = line_cnt_q;
      to_cnt_d     = to_cnt_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (in_valid_i) begin
         to_cnt_d = '0;
         if (w_is_sep && w_is_eol) begin
            eol_d        = 1'b1;
            line_bytes_d = line_cnt_q;
            line_cnt_d   = 8'd0;
         end
         if (state_q == c_ST_EXPECT_HI) begin
            if (w_is_digit) begin
               hi_d    = w_nib;
               state_d = c_ST_EXPECT_LO;
            end else if (!w_is_sep) begin
               err_valid_d = 1'b1;
               err_code_d  = c_ERR_BADCHR;
            end
         end else begin
            state_d = c_ST_EXPECT_HI;
            hi_d    = 4'd0;
            if (w_is_digit) begin
               // A byte may load when the slot is empty or being drained this cycle
               if (!out_valid_q || out_ready_i) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {hi_q, w_nib};
                  if (line_cnt_q != 8'hFF) begin
                     line_cnt_d = line_cnt_q + 8'd1;
                  end
               end else begin
                  err_valid_d = 1'b1;
                  err_code_d  = c_ERR_OVERRUN;
               end
            end else begin
               err_valid_d = 1'b1;
               err_code_d  = w_is_sep ? c_ERR_ODD : c_ERR_BADCHR;
            end
         end
      end else if (state_q == c_ST_EXPECT_LO && TIMEOUT_CYCLES != 0) begin
         if (to_cnt_q == c_TO_LAST) begin
            err_valid_d = 1'b1;
            err_code_d  = c_ERR_TIMEOUT;
            state_d     = c_ST_EXPECT_HI;
            hi_d        = 4'd0;
            to_cnt_d    = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= c_ST_EXPECT_HI;
         hi_q         <= 4'd0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'd0;
         err_valid_q  <= 1'b0;
         err_code_q   <= 2'd0;
         eol_q        <= 1'b0;
         line_bytes_q <= 8'd0;
         line_cnt_q   <= 8'd0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         eol_q        <= eol_d;
         line_bytes_q <= line_bytes_d;
         line_cnt_q   <= line_cnt_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign err_valid_o  = err_valid_q;
   assign err_code_o   = err_code_q;
   assign eol_o        = eol_q;
   assign line_bytes_o = line_bytes_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_ascii_decoder.sv
// ============================================================================
// tb_hex_ascii_decoder : directed vectors for hex_ascii_decoder (upper/lower)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_ascii_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b1;

   logic       a_out_valid, a_err_valid, a_eol;
   logic [7:0] a_out_data, a_line_bytes;
   logic [1:0] a_err_code;
   logic       b_out_valid, b_err_valid, b_eol;
   logic [7:0] b_out_data, b_line_bytes;
   logic [1:0] b_err_code;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hex_ascii_decoder #(.LOWERCASE_EN(1'b1), .TIMEOUT_CYCLES(100)) dut_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(out_ready),
      .err_valid_o(a_err_valid), .err_code_o(a_err_code),
      .eol_o(a_eol), .line_bytes_o(a_line_bytes)
   );

   hex_ascii_decoder #(.LOWERCASE_EN(1'b0), .TIMEOUT_CYCLES(100)) dut_b (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(out_ready),
      .err_valid_o(b_err_valid), .err_code_o(b_err_code),
      .eol_o(b_eol), .line_bytes_o(b_line_bytes)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the processing edge
   task automatic strobe(input logic [7:0] ch);
      in_valid = 1'b1;
      in_data  = ch;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic early_err;

      @(negedge clk);
      chk("rst_out_valid", a_out_valid, 1'b0);
      chk("rst_out_data", a_out_data, 8'h00);
      chk("rst_err_valid", a_err_valid, 1'b0);
      chk("rst_err_code", a_err_code, 2'd0);
      chk("rst_eol", a_eol, 1'b0);
      chk("rst_line_bytes", a_line_bytes, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // "41" with ready high
      strobe("4");
      chk("41_hi_no_valid", a_out_valid, 1'b0);
      strobe("1");
      chk("41_valid", a_out_valid, 1'b1);
      chk("41_data", a_out_data, 8'h41);
      chk("41_no_err", a_err_valid, 1'b0);
      @(negedge clk);
      chk("41_drained", a_out_valid, 1'b0);

      // "aF\r" on both lowercase settings
      do_reset();
      strobe("a");
      chk("lc1_a_no_err", a_err_valid, 1'b0);
      chk("lc0_a_err", b_err_valid, 1'b1);
      chk("lc0_a_code", b_err_code, 2'd2);
      strobe("F");
      chk("lc1_F_valid", a_out_valid, 1'b1);
      chk("lc1_F_data", a_out_data, 8'hAF);
      chk("lc0_F_no_valid", b_out_valid, 1'b0);
      chk("lc0_F_no_err", b_err_valid, 1'b0);
      strobe(8'h0D);
      chk("lc1_eol", a_eol, 1'b1);
      chk("lc1_line_bytes", a_line_bytes, 8'd1);
      chk("lc1_cr_no_err", a_err_valid, 1'b0);
      chk("lc0_cr_err", b_err_valid, 1'b1);
      chk("lc0_cr_code", b_err_code, 2'd1);
      chk("lc0_cr_eol", b_eol, 1'b1);
      @(negedge clk);
      chk("eol_one_cycle", a_eol, 1'b0);

      // "3\r": odd nibble and eol together
      do_reset();
      strobe("3");
      strobe(8'h0D);
      chk("odd_err", a_err_valid, 1'b1);
      chk("odd_code", a_err_code, 2'd1);
      chk("odd_eol", a_eol, 1'b1);
      chk("odd_line_bytes", a_line_bytes, 8'd0);
      chk("odd_no_valid", a_out_valid, 1'b0);

      // Overrun with ready low, then LF reports only the loaded byte
      do_reset();
      out_ready = 1'b0;
      strobe("1");
      strobe("2");
      strobe("3");
      strobe("4");
      chk("ovr_err", a_err_valid, 1'b1);
      chk("ovr_code", a_err_code, 2'd3);
      chk("ovr_held", a_out_data, 8'h12);
      chk("ovr_valid", a_out_valid, 1'b1);
      strobe(8'h0A);
      chk("ovr_line_bytes", a_line_bytes, 8'd1);

      // Byte completes in the same cycle the held byte is accepted
      do_reset();
      out_ready = 1'b0;
      strobe("1");
      strobe("2");
      strobe("3");
      out_ready = 1'b1;
      strobe("4");
      chk("acc_valid", a_out_valid, 1'b1);
      chk("acc_data", a_out_data, 8'h34);
      chk("acc_no_err", a_err_valid, 1'b0);
      strobe(8'h0D);
      chk("acc_line_bytes", a_line_bytes, 8'd2);

      // Timeout after '7' with TIMEOUT_CYCLES=100
      do_reset();
      strobe("7");
      early_err = 1'b0;
      for (int i = 1; i < 100; i++) begin
         if (a_err_valid) early_err = 1'b1;
         @(negedge clk);
      end
      if (a_err_valid) early_err = 1'b1;
      chk("to_not_early", early_err, 1'b0);
      @(negedge clk);
      chk("to_err", a_err_valid, 1'b1);
      chk("to_code", a_err_code, 2'd0);
      strobe("8");
      strobe("9");
      chk("to_after_data", a_out_data, 8'h89);
      chk("to_after_valid", a_out_valid, 1'b1);

      // Asynchronous reset in EXPECT_LO with a held byte
      do_reset();
      out_ready = 1'b0;
      strobe("1");
      strobe("2");
      strobe("5");
      chk("pre_rst_valid", a_out_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_valid", a_out_valid, 1'b0);
      chk("arst_data", a_out_data, 8'h00);
      chk("arst_err", a_err_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      strobe("6");
      chk("post_rst_no_err", a_err_valid, 1'b0);
      strobe("0");
      chk("post_rst_data", a_out_data, 8'h60);
      chk("post_rst_valid", a_out_valid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hex_ascii_decoder.md
HEX_ASCII_DECODER -- requirements
Module: hex_ascii_decoder

Interface
REQ-001 Parameter LOWERCASE_EN, default 1: when 1, 'a'-'f' are accepted as hex digits.
REQ-002 Parameter TIMEOUT_CYCLES, default 12_000_000: maximum idle cycles allowed between high and low nibble; 0 disables the timeout.
REQ-003 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1  one-cycle strobe; in_data holds a received ASCII character.
REQ-006 in_data  in  8  received ASCII character.
REQ-007 out_valid  out  1  decoded byte available; held until accepted.
REQ-008 out_data  out  8  decoded byte; stable while out_valid=1.
REQ-009 out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-010 err_valid  out  1  one-cycle error strobe.
REQ-011 err_code  out  2  error type, valid with err_valid: 0 timeout, 1 odd nibble, 2 bad char, 3 overrun.
REQ-012 eol  out  1  one-cycle strobe on CR (0x0D) or LF (0x0A).
REQ-013 line_bytes  out  8  bytes decoded since the previous eol, saturating at 255; valid with eol.

Function
REQ-014 Hex digits: 0x30-0x39 -> 0-9; 0x41-0x46 -> 10-15; 0x61-0x66 -> 10-15 only when LOWERCASE_EN=1.
REQ-015 Separators: 0x20, 0x0D and 0x0A; every other character is a bad char.
REQ-016 FSM states: EXPECT_HI (reset state) and EXPECT_LO; a 4-bit high-nibble register holds the pending digit.
REQ-017 In EXPECT_HI, a digit stores the high nibble and moves the FSM to EXPECT_LO.
REQ-018 In EXPECT_HI, a separator is ignored, except that CR/LF pulse eol.
REQ-019 In EXPECT_HI, a bad char pulses err code 2 and leaves the FSM in EXPECT_HI.
REQ-020 In EXPECT_LO, a digit forms {hi,lo}, loads the output register, increments the line count and returns the FSM to EXPECT_HI.
REQ-021 In EXPECT_LO, a separator pulses err code 1, discards the nibble and returns the FSM to EXPECT_HI; CR/LF also pulse eol in the same cycle.
REQ-022 In EXPECT_LO, a bad char pulses err code 2, discards the nibble and returns the FSM to EXPECT_HI.
REQ-023 Latency: a low-nibble strobe in cycle N asserts out_valid and out_data in cycle N+1.
REQ-024 out_valid stays high until a cycle with out_ready=1, and deasserts at the following edge.
REQ-025 Overrun: if a byte completes while out_valid=1 and out_ready=0, the new byte is dropped, err code 3 pulses and the held byte is unchanged.
REQ-026 If a byte completes in the same cycle that the held byte is accepted, the new byte loads, out_valid stays 1 and no error is raised.
REQ-027 Timeout counter runs only in EXPECT_LO and clears on every in_valid.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1 with no in_valid, err code 0 pulses and the FSM returns to EXPECT_HI.
REQ-029 A strobe arriving in the same cycle as the timeout takes priority over the timeout.
REQ-030 eol presents the line count (line_bytes) in the same cycle, and the count clears to 0 at that edge.
REQ-031 The line count counts only bytes actually loaded; overrun-dropped bytes are not counted.
REQ-032 Only one err_valid pulse is produced per cycle; at most one error condition can arise per strobe.
REQ-033 in_valid asserted for several consecutive cycles is treated as one character per cycle.

Reset
REQ-034 RST=1 asynchronously forces: FSM to EXPECT_HI; out_valid, err_valid and eol to 0; out_data, err_code, line_bytes, nibble register and timeout counter to 0.
REQ-035 Asserting RST in EXPECT_LO discards the pending nibble, and no error is reported for it.
REQ-036 After RST deasserts, the first in_valid edge is processed normally.

Structure
REQ-037 The error codes, FSM state encodings and the ASCII constants (CR, LF, space) belong in a shared package, hex_ascii_pkg.
REQ-038 Character classification (digit value, is_digit, is_sep, is_eol) is one combinational sub-module, ascii_to_nibble, the inverse of the existing nibble-to-ASCII logic.
REQ-039 All remaining logic is registered in hex_ascii_decoder.

Verification
REQ-040 "4","1" with out_ready=1 -> out_valid one cycle after '1', out_data=0x41, no err_valid.
REQ-041 "a","F","\r" with LOWERCASE_EN=1 -> out_data=0xAF, then eol with line_bytes=1; with LOWERCASE_EN=0 -> err code 2 on 'a', and 'F' becomes a pending high nibble.
REQ-042 "3","\r" -> err code 1 and eol in the same cycle, line_bytes=0, no out_valid.
REQ-043 "12","34" with out_ready=0 -> out_data=0x12 held and err code 3 at '4'; setting out_ready=1 on the cycle '4' completes -> out_data=0x34 and no error.
REQ-044 TIMEOUT_CYCLES=100, "7" then silence -> err code 0 exactly 100 cycles after '7'; a following "8","9" yields 0x89.
REQ-045 RST pulsed while in EXPECT_LO after "5" -> all outputs 0 immediately; a following "6","0" yields 0x60.
